// File: rtl/cascaded_dff_pkg.sv
// Shared constants for the cascaded_dff serial-in, parallel-out shift register.
// The optional serial-out tap is enabled by defining CASCADED_DFF_SOUT_EN.
package cascaded_dff_pkg;

    // Default number of cascaded stages (one LED bank worth of bits).
    localparam int CASCADED_DFF_DEF_WIDTH = 8;

    // Value every stage takes on reset; the full-word reset value is built from it.
    localparam logic CASCADED_DFF_RESET_BIT = 1'b0;

    // Builds a full-width reset word from the per-stage reset bit.
    function automatic logic [CASCADED_DFF_DEF_WIDTH-1:0] cascaded_dff_def_reset_val();
        return {CASCADED_DFF_DEF_WIDTH{CASCADED_DFF_RESET_BIT}};
    endfunction

endpackage

// File: rtl/cascaded_dff_stage.sv
// Single D flip-flop stage with synchronous active-high reset to a
// per-stage reset value. Used as the building block of cascaded_dff.
// Not affected by CASCADED_DFF_SOUT_EN.
module dff_stage
    import cascaded_dff_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic D,
    input  logic RST_VAL,
    output logic Q
);

    // Capture D on every rising edge, or load the reset value when RESET is high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Q <= RST_VAL;
        end else begin
            Q <= D;
        end
    end

endmodule

// File: rtl/cascaded_dff.sv
// Serial-in, parallel-out shift register built from a chain of dff_stage
// flip-flops. New bits enter at Q[WIDTH-1] and move toward Q[0], so after
// WIDTH edges the first bit applied sits in Q[0].
// Defining CASCADED_DFF_SOUT_EN adds a DATA_OUT port equal to Q[0], a
// serial-out tap for chaining instances.
module cascaded_dff
    import cascaded_dff_pkg::*;
#(
    parameter int               WIDTH     = CASCADED_DFF_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{CASCADED_DFF_RESET_BIT}}
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DATA_IN,
`ifdef CASCADED_DFF_SOUT_EN
    output logic             DATA_OUT,
`endif
    output logic [WIDTH-1:0] Q
);

    // D input of each stage: the top stage takes the serial input, every
    // other stage takes the output of the stage above it.
    logic [WIDTH-1:0] stage_d;

    assign stage_d = {DATA_IN, Q[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        dff_stage u_stage (
            .CLK     (CLK),
            .RESET   (RESET),
            .D       (stage_d[i]),
            .RST_VAL (RESET_VAL[i]),
            .Q       (Q[i])
        );
    end

`ifdef CASCADED_DFF_SOUT_EN
    // The oldest bit doubles as the serial output for the next instance.
    assign DATA_OUT = Q[0];
`endif

endmodule

// File: tb/tb_cascaded_dff.sv
// Directed self-checking bench for cascaded_dff (WIDTH = 8).
// With CASCADED_DFF_SOUT_EN defined it also checks the DATA_OUT tap.
module tb_cascaded_dff;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             dataIn;
    logic [WIDTH-1:0] q;
`ifdef CASCADED_DFF_SOUT_EN
    logic             dataOut;
`endif

    int checkCount;
    int errorCount;

    cascaded_dff #(
        .WIDTH     (WIDTH),
        .RESET_VAL (8'h00)
    ) dut (
        .CLK      (clk),
        .RESET    (reset),
        .DATA_IN  (dataIn),
`ifdef CASCADED_DFF_SOUT_EN
        .DATA_OUT (dataOut),
`endif
        .Q        (q)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives reset and serial data on the falling edge, then lets one rising
    // edge pass and settles 1 timestep so outputs can be sampled.
    task automatic applyStimulus(input logic rst, input logic din);
        @(negedge clk);
        reset  = rst;
        dataIn = din;
        @(posedge clk);
        #1;
    endtask

    // Counts one comparison and reports any mismatch (4-state compare).
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Hand-computed Q after each bit of the word 1,0,1,1,0,1,0,1.
    logic       wordBits [WIDTH] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] wordExp  [WIDTH] = '{8'h80, 8'h40, 8'hA0, 8'hD0, 8'h68, 8'hB4, 8'h5A, 8'hAD};

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b0;
        dataIn     = 1'b0;

        // Garbage then reset: a reset edge with DATA_IN=1 must still clear Q.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset", q, 8'h00);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reset_hold", q, 8'h00);

        // Word load, checked after every edge.
        for (int i = 0; i < WIDTH; i++) begin
            applyStimulus(1'b0, wordBits[i]);
            checkOutput($sformatf("word_%0d", i), q, wordExp[i]);
        end

        // Single-bit walk from MSB to LSB, then out of the register.
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i <= WIDTH; i++) begin
            applyStimulus(1'b0, (i == 0) ? 1'b1 : 1'b0);
            checkOutput($sformatf("walk_%0d", i), q, 8'h80 >> i);
`ifdef CASCADED_DFF_SOUT_EN
            checkOutput($sformatf("sout_%0d", i), {7'd0, dataOut},
                        (i == WIDTH - 1) ? 8'h01 : 8'h00);
`endif
        end

        // All ones, then drain with zeros.
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("ones", q, 8'hFF);
        for (int i = 0; i < WIDTH; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("drain_%0d", i), q, 8'hFF >> (i + 1));
        end

        // Reset in the middle of a stream of ones, then resume shifting.
        for (int i = 0; i < WIDTH; i++) begin
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("mid_full", q, 8'hFF);
        applyStimulus(1'b1, 1'b1);
        checkOutput("mid_reset", q, 8'h00);
        applyStimulus(1'b0, 1'b1);
        checkOutput("mid_resume", q, 8'h80);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
